qspi_mem_responder: RTL and testbench
=====================================

QSPI_MEM_RESPONDER -- requirements
Module: qspi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, byte count of internal memory (power of two, 16..256).
REQ-002 SHALL have parameter ADDRW, default 24, address bits received per command.
REQ-003 SHALL have port clk, input, 1, single system clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port qspi_sclk, input, 1, serial clock from memory controller.
REQ-006 SHALL have port qspi_cs_n, input, 1, chip select, active-low.
REQ-007 SHALL have port qspi_io_in, input, 4, IO lines driven by controller.
REQ-008 SHALL have port qspi_io_out, output, 4, IO lines driven by responder.
REQ-009 SHALL have port qspi_io_oe, output, 4, output enable, 1 = responder drives.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 SHALL pass qspi_sclk, qspi_cs_n and qspi_io_in through 2-flop synchronizers; the design requires clk >= 4x qspi_sclk.
REQ-012 SHALL use SPI mode 0: sample on detected sclk rising edge, update qspi_io_out on detected falling edge.
REQ-013 SHALL implement states IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
REQ-014 SHALL leave IDLE for CMD on synchronized cs_n falling.
REQ-015 CMD: SHALL shift 8 bits from io[0], MSB first, one per rising edge.
REQ-016 SHALL accept opcode 0xEB (quad read) and 0x38 (quad write); any other opcode -> IGNORE until cs_n high.
REQ-017 ADDR: SHALL shift ADDRW/4 nibbles from io[3:0], high nibble first; memory index = address mod DEPTH.
REQ-018 0xEB: after ADDR, SHALL spend exactly 4 rising edges in DUMMY, fetching byte at index during DUMMY.
REQ-019 RD_DATA: qspi_io_oe SHALL be 4'hF from the falling edge after the last dummy rising edge; each byte sent high nibble first.
REQ-020 RD_DATA: after each low nibble, index SHALL increment, wrapping DEPTH-1 -> 0.
REQ-021 WR_DATA: SHALL assemble byte from two rising-edge nibbles (high first) and write it on the second; index increments with same wrap.
REQ-022 qspi_io_oe SHALL be 4'h0 in every state except RD_DATA.
REQ-023 cs_n rising in any state SHALL return to IDLE within 3 clk, force qspi_io_oe=0, discard incomplete write byte.
REQ-024 cs_n rising and sclk edge detected in same clk: cs_n SHALL take priority; the edge is ignored.
REQ-025 Unbounded data phase SHALL be legal; transaction ends only on cs_n rising.

Reset
REQ-026 While rst_n low: state IDLE, qspi_io_out=0, qspi_io_oe=0, busy=0, synchronizers set to idle levels (sclk=0, cs_n=1).
REQ-027 Memory contents SHALL reset to 0x00.
REQ-028 rst_n asserted mid-transaction SHALL abort immediately; after release, responder waits for a fresh cs_n falling edge.

Configuration
REQ-029 With macro QSPI_RESP_WRITE_EN defined, 0x38 SHALL be supported per REQ-021.
REQ-030 Without QSPI_RESP_WRITE_EN, 0x38 SHALL be treated as unsupported (IGNORE), and memory is read-only, holding reset values.

Structure
REQ-031 Opcode constants, state encoding and nibble/byte widths SHALL live in shared package qspi_pkg.
REQ-032 Synchronizer plus edge detection SHALL be sub-module qspi_edge_sync, instantiated once per synchronized input.

Verification
REQ-033 Write 0x38, addr 0x000010, data 0xA5 0x3C; read 0xEB addr 0x000010, 2 bytes -> io nibbles A,5,3,C, oe=F only in data phase.
REQ-034 Write 0x11 at addr 0x00003F (DEPTH=64), continue 0x22 -> read addr 0x000000 returns 0x22 (wrap).
REQ-035 Opcode 0x9F then 20 sclk cycles -> oe stays 0, busy high until cs_n high, memory unchanged.
REQ-036 cs_n raised after one nibble of write data at addr 0x05 -> addr 0x05 still 0x00, busy=0 within 3 clk.
REQ-037 rst_n pulsed low during RD_DATA -> oe=0 and busy=0 same cycle; next 0xEB read of addr 0 returns 0x00.
REQ-038 Build without QSPI_RESP_WRITE_EN, issue 0x38 write 0xFF at addr 0 -> read of addr 0 returns 0x00.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared constants, state encoding and opcode decode for the QSPI memory responder.
// QSPI_RESP_WRITE_EN enables the 0x38 quad-write opcode; without it memory is read-only.
package qspi_pkg;

  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 8;
  localparam int DUMMY_EDGES = 4;

  localparam logic [BYTE_W-1:0] OP_QREAD  = 8'hEB;
  localparam logic [BYTE_W-1:0] OP_QWRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  function automatic logic op_ok(input logic [BYTE_W-1:0] op);
`ifdef QSPI_RESP_WRITE_EN
    return (op == OP_QREAD) || (op == OP_QWRITE);
`else
    return (op == OP_QREAD);
`endif
  endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronizer with edge detect on bit 0.
// RST_VAL sets the idle level the chain holds in reset.
module qspi_edge_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] ff1;
  logic         prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1  <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL[0];
    end else begin
      ff1  <= din;
      q    <= ff1;
      prev <= q[0];
    end
  end

  assign rise = q[0] & ~prev;
  assign fall = ~q[0] & prev;

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI mode-0 memory responder: 0xEB quad read, optional 0x38 quad write.
// Quad write is compiled in only when QSPI_RESP_WRITE_EN is defined.
module qspi_mem_responder
  import qspi_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDRW = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qspi_sclk,
  input  logic       qspi_cs_n,
  input  logic [3:0] qspi_io_in,
  output logic [3:0] qspi_io_out,
  output logic [3:0] qspi_io_oe,
  output logic       busy
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int ADDR_NIBS = ADDRW / NIB_W;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  logic             sclk_rise, sclk_fall;
  logic             cs_rise, cs_fall;
  logic [NIB_W-1:0] io;
  logic             unused_sclk, unused_cs;
  logic             unused_io_rise, unused_io_fall;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic [6:0]        cmd;
  logic [BYTE_W-1:0] op_now;
  logic              is_wr;
  logic [IDX_W-1:0]  idx;
  logic [BYTE_W-1:0] rd_byte;
  logic              hi_nib;
  logic [BYTE_W-1:0] mem [DEPTH];

  qspi_edge_sync #(.W(1), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(qspi_sclk), .q(unused_sclk),
    .rise(sclk_rise), .fall(sclk_fall)
  );

  qspi_edge_sync #(.W(1), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(qspi_cs_n), .q(unused_cs),
    .rise(cs_rise), .fall(cs_fall)
  );

  qspi_edge_sync #(.W(NIB_W), .RST_VAL('0)) u_io (
    .clk(clk), .rst_n(rst_n), .din(qspi_io_in), .q(io),
    .rise(unused_io_rise), .fall(unused_io_fall)
  );

  assign op_now = {cmd, io[0]};
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // cs_n rising wins over any sclk edge seen in the same cycle
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (cs_fall) state_nxt = ST_CMD;
        ST_CMD:
          if (sclk_rise && cnt == 8'd7)
            state_nxt = op_ok(op_now) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:
          if (sclk_rise && cnt == 8'(ADDR_NIBS - 1))
            state_nxt = is_wr ? ST_WR_DATA : ST_DUMMY;
        ST_DUMMY:
          if (sclk_rise && cnt == 8'(DUMMY_EDGES - 1))
            state_nxt = ST_RD_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cmd         <= '0;
      is_wr       <= 1'b0;
      idx         <= '0;
      rd_byte     <= '0;
      hi_nib      <= 1'b1;
      qspi_io_out <= '0;
      qspi_io_oe  <= '0;
    end else if (cs_rise) begin
      cnt        <= '0;
      hi_nib     <= 1'b1;
      qspi_io_oe <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt    <= '0;
          hi_nib <= 1'b1;
        end
        ST_CMD:
          if (sclk_rise) begin
            cmd   <= op_now[6:0];
            is_wr <= (op_now == OP_QWRITE);
            cnt   <= (cnt == 8'd7) ? '0 : cnt + 8'd1;
          end
        ST_ADDR:
          if (sclk_rise) begin
            idx <= IDX_W'({idx, io});
            cnt <= (cnt == 8'(ADDR_NIBS - 1)) ? '0 : cnt + 8'd1;
          end
        ST_DUMMY:
          if (sclk_rise) begin
            rd_byte <= mem[idx];
            cnt     <= (cnt == 8'(DUMMY_EDGES - 1)) ? '0 : cnt + 8'd1;
          end
        ST_RD_DATA:
          if (sclk_fall) begin
            qspi_io_oe  <= 4'hF;
            qspi_io_out <= hi_nib ? rd_byte[7:4] : rd_byte[3:0];
            hi_nib      <= ~hi_nib;
            if (!hi_nib) begin
              idx     <= idx + IDX_ONE;
              rd_byte <= mem[idx + IDX_ONE];
            end
          end
        ST_WR_DATA:
          if (sclk_rise) begin
            hi_nib <= ~hi_nib;
            if (!hi_nib) idx <= idx + IDX_ONE;
          end
        default: ;
      endcase
    end
  end

`ifdef QSPI_RESP_WRITE_EN
  logic [NIB_W-1:0] wr_hi;
  logic             wr_en;

  assign wr_en = (state == ST_WR_DATA) && sclk_rise && !cs_rise && !hi_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_hi <= '0;
    else if (state == ST_WR_DATA && sclk_rise && hi_nib) wr_hi <= io;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= {wr_hi, io};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed plus randomized checks of the QSPI responder against a byte-array memory model.
// Write expectations follow QSPI_RESP_WRITE_EN as compiled.
module tb_qspi_mem_responder;

  localparam int DEPTH = 64;
  localparam int ADDRW = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       qspi_sclk = 1'b0;
  logic       qspi_cs_n = 1'b1;
  logic [3:0] qspi_io_in = 4'h0;
  logic [3:0] qspi_io_out;
  logic [3:0] qspi_io_oe;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem_m [DEPTH];
  logic [7:0] wbuf  [8];

  always #5 clk = ~clk;

  qspi_mem_responder #(.DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .qspi_sclk(qspi_sclk),
    .qspi_cs_n(qspi_cs_n),
    .qspi_io_in(qspi_io_in),
    .qspi_io_out(qspi_io_out),
    .qspi_io_oe(qspi_io_oe),
    .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one full sclk period; samples the responder just before the falling edge
  task automatic sck(input logic [3:0] nib, output logic [3:0] o, output logic [3:0] oe);
    qspi_io_in = nib;
    step(4);
    qspi_sclk = 1'b1;
    step(4);
    o  = qspi_io_out;
    oe = qspi_io_oe;
    qspi_sclk = 1'b0;
  endtask

  task automatic begin_txn(input logic [7:0] op);
    logic [3:0] o, oe;
    logic [2:0] r;
    qspi_cs_n = 1'b0;
    step(4);
    for (int i = 7; i >= 0; i--) begin
      r = 3'($urandom);
      sck({r, op[i]}, o, oe);
      check("cmd_oe", 32'(oe), 32'h0);
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] o, oe;
    for (int k = 5; k >= 0; k--) begin
      sck(a[4*k +: 4], o, oe);
      check("addr_oe", 32'(oe), 32'h0);
    end
  endtask

  task automatic end_txn();
    step(4);
    check("busy_txn", 32'(busy), 32'h1);
    qspi_cs_n = 1'b1;
    step(3);
    check("busy_end", 32'(busy), 32'h0);
    check("oe_end", 32'(qspi_io_oe), 32'h0);
    step(4);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] o, oe;
    logic [7:0] exp;
    begin_txn(8'hEB);
    send_addr(a);
    for (int d = 0; d < 4; d++) begin
      sck(4'($urandom), o, oe);
      check("dummy_oe", 32'(oe), 32'h0);
    end
    for (int b = 0; b < n; b++) begin
      exp = mem_m[(int'(a) + b) % DEPTH];
      sck(4'($urandom), o, oe);
      check("rd_oe", 32'(oe), 32'hF);
      check("rd_hi", 32'(o), 32'(exp[7:4]));
      sck(4'($urandom), o, oe);
      check("rd_oe", 32'(oe), 32'hF);
      check("rd_lo", 32'(o), 32'(exp[3:0]));
    end
    end_txn();
  endtask

  task automatic do_write(input logic [23:0] a, input int n, input bit half);
    logic [3:0] o, oe;
    begin_txn(8'h38);
    send_addr(a);
    for (int b = 0; b < n; b++) begin
      sck(wbuf[b][7:4], o, oe);
      check("wr_oe", 32'(oe), 32'h0);
      sck(wbuf[b][3:0], o, oe);
      check("wr_oe", 32'(oe), 32'h0);
    end
    if (half) begin
      sck(4'($urandom), o, oe);
      check("wr_oe", 32'(oe), 32'h0);
    end
    end_txn();
`ifdef QSPI_RESP_WRITE_EN
    for (int b = 0; b < n; b++) mem_m[(int'(a) + b) % DEPTH] = wbuf[b];
`endif
  endtask

  initial begin
    logic [3:0]  o, oe;
    logic [23:0] ra;
    int          rn;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

    step(3);
    check("rst_oe", 32'(qspi_io_oe), 32'h0);
    check("rst_out", 32'(qspi_io_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step(6);
    check("idle_busy", 32'(busy), 32'h0);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(24'h000010, 2, 1'b0);
    do_read(24'h000010, 2);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(24'h00003F, 2, 1'b0);
    do_read(24'h00003F, 2);
    do_read(24'h000000, 1);

    begin_txn(8'h9F);
    for (int i = 0; i < 20; i++) begin
      sck(4'($urandom), o, oe);
      check("ign_oe", 32'(oe), 32'h0);
      check("ign_busy", 32'(busy), 32'h1);
    end
    end_txn();
    do_read(24'h00003E, 4);

    wbuf[0] = 8'h77;
    do_write(24'h000005, 0, 1'b1);
    do_read(24'h000005, 1);

    wbuf[0] = 8'h5A;
    do_write(24'h000001, 1, 1'b0);
    begin_txn(8'hEB);
    send_addr(24'h000000);
    for (int d = 0; d < 4; d++) sck(4'h0, o, oe);
    sck(4'h0, o, oe);
    check("pre_rst_oe", 32'(oe), 32'hF);
    qspi_sclk = 1'b1;
    step(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(qspi_io_oe), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    qspi_sclk = 1'b0;
    qspi_cs_n = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(6);
    do_read(24'h000000, 2);

    wbuf[0] = 8'hFF;
    do_write(24'h000000, 1, 1'b0);
    do_read(24'h000000, 1);

    for (int t = 0; t < 6; t++) begin
      ra = 24'($urandom);
      rn = int'($urandom_range(1, 4));
      for (int b = 0; b < rn; b++) wbuf[b] = 8'($urandom);
      do_write(ra, rn, 1'($urandom));
      do_read(ra, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
